// File: rtl/srff_driver_if.sv
// Handshake and excitation bundle between a target source, the SR driver and
// the external SR flip-flop bank it steers.
interface srff_driver_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] tgt;        // requested state word for the bank
  logic             tgt_valid;  // tgt is valid this cycle
  logic             tgt_ready;  // driver idle, tgt may be offered
  logic [WIDTH-1:0] q_fb;       // current q of the external bank
  logic [WIDTH-1:0] s_out;      // set excitation per flip-flop
  logic [WIDTH-1:0] r_out;      // reset excitation per flip-flop
  logic             done;       // one-cycle pulse, bank reached target
  logic             err;        // target not reached within retry budget
  logic [3:0]       retry_cnt;  // re-drives spent on the current target

  // Target source / flip-flop bank side
  modport master (
    output tgt,
    output tgt_valid,
    output q_fb,
    input  tgt_ready,
    input  s_out,
    input  r_out,
    input  done,
    input  err,
    input  retry_cnt
  );

  // Driver side
  modport slave (
    input  tgt,
    input  tgt_valid,
    input  q_fb,
    output tgt_ready,
    output s_out,
    output r_out,
    output done,
    output err,
    output retry_cnt
  );

endinterface

// File: rtl/srff_driver.sv
// SR flip-flop bank driver: accepts a target word, pulses set/reset
// excitation for one cycle, lets the bank settle, compares the fed-back q
// against the target and re-drives up to MAX_RETRY times before flagging err.
// All state moves on the falling edge of clk.
module srff_driver #(
  parameter int WIDTH     = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic          clk,
  input  logic          reset,
  srff_driver_if.slave  bus
);

  // Retry counter is 4 bits wide, so the budget is compared at that width.
  localparam logic [3:0] LP_MAX_RETRY = 4'(MAX_RETRY);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_CHECK  = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_tgt_q;
  logic [WIDTH-1:0] r_s_out;
  logic [WIDTH-1:0] r_r_out;
  logic             r_done;
  logic             r_err;
  logic [3:0]       r_retry_cnt;

  logic [WIDTH-1:0] w_drv_tgt;
  logic [WIDTH-1:0] w_s_next;
  logic [WIDTH-1:0] w_r_next;
  logic             w_match;
  logic             w_can_retry;

  // The first drive of a target uses the word arriving on the bus (it is
  // being latched on the same edge); every re-drive uses the latched copy.
  assign w_drv_tgt = (r_state == ST_IDLE) ? bus.tgt : r_tgt_q;

  // Per-bit excitation: only bits whose q disagrees with the target are
  // pushed. Set needs target=1/q=0, reset needs target=0/q=1, so the two
  // terms are mutually exclusive and S=R=1 can never be produced.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_excite
    assign w_s_next[gi] =  w_drv_tgt[gi] & ~bus.q_fb[gi];
    assign w_r_next[gi] = ~w_drv_tgt[gi] &  bus.q_fb[gi];
  end

  assign w_match     = (bus.q_fb == r_tgt_q);
  assign w_can_retry = (r_retry_cnt < LP_MAX_RETRY);

  // Sequencer: accept -> drive one cycle -> settle -> check, with retries.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_tgt_q     <= '0;
      r_s_out     <= '0;
      r_r_out     <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_retry_cnt <= 4'd0;
    end else begin
      // done is a single-cycle pulse unless CHECK re-asserts it below
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.tgt_valid) begin
            r_tgt_q     <= bus.tgt;
            r_retry_cnt <= 4'd0;
            r_err       <= 1'b0;
            r_s_out     <= w_s_next;
            r_r_out     <= w_r_next;
            r_state     <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          // Excitation lives for exactly one cycle per attempt.
          r_s_out <= '0;
          r_r_out <= '0;
          r_state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          // Give the bank a full cycle before its q is trusted.
          r_state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (w_match) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else if (w_can_retry) begin
            r_retry_cnt <= r_retry_cnt + 4'd1;
            r_s_out     <= w_s_next;
            r_r_out     <= w_r_next;
            r_state     <= ST_DRIVE;
          end else begin
            // Budget exhausted: retry_cnt keeps its final value for readback.
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_s_out <= '0;
          r_r_out <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Ready is purely the idle decode so it reads 1 throughout reset.
  assign bus.tgt_ready = (r_state == ST_IDLE);
  assign bus.s_out     = r_s_out;
  assign bus.r_out     = r_r_out;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.retry_cnt = r_retry_cnt;

endmodule

// File: tb/tb_srff_driver.sv
// Directed bench for srff_driver (WIDTH=8, MAX_RETRY=3) with a behavioural
// SR flip-flop bank that updates q on the falling edge.
module tb_srff_driver;

  logic clk;
  logic reset;

  int checks;
  int failures;

  // Behavioural SR bank controls
  logic       q_load_en;
  logic [7:0] q_load_val;
  logic [7:0] stuck0;
  logic [7:0] q_bank;

  srff_driver_if #(.WIDTH(8)) bus ();

  srff_driver #(
    .WIDTH     (8),
    .MAX_RETRY (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Falling-edge clock domain: negedges at 10, 20, 30 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SR bank: q follows set/reset on the falling edge; stuck0 bits never rise.
  always @(negedge clk) begin
    if (q_load_en) q_bank <= q_load_val;
    else           q_bank <= ((q_bank & ~bus.r_out) | bus.s_out) & ~stuck0;
  end
  assign bus.q_fb = q_bank;

  logic [1:0] st;
  assign st = dut.r_state;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge (mid-cycle for this design).
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Excitation must never be S=R=1 and must be idle outside DRIVE.
  always @(posedge clk) begin
    if (reset) begin
      chk("sr_exclusive", 32'(bus.s_out & bus.r_out), 32'd0);
      if (st != 2'd1) chk("sr_quiet_outside_drive", 32'(bus.s_out | bus.r_out), 32'd0);
    end
  end

  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b0;
    bus.tgt       = 8'h00;
    bus.tgt_valid = 1'b0;
    q_load_en  = 1'b1;
    q_load_val = 8'h00;
    stuck0     = 8'h00;

    // ---- reset state ----
    cyc();
    chk("rst_ready", 32'(bus.tgt_ready), 32'd1);
    chk("rst_s_out", 32'(bus.s_out), 32'h00);
    chk("rst_r_out", 32'(bus.r_out), 32'h00);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_retry", 32'(bus.retry_cnt), 32'd0);

    // ---- async reset mid-DRIVE; accept on first edge after release ----
    reset = 1'b1; q_load_en = 1'b0;
    bus.tgt = 8'hA5; bus.tgt_valid = 1'b1;
    cyc();
    bus.tgt_valid = 1'b0;
    $display("txn accept tgt=0xA5 q=0x00 before async reset");
    chk("arst_pre_s_out", 32'(bus.s_out), 32'hA5);
    chk("arst_pre_ready", 32'(bus.tgt_ready), 32'd0);
    #1 reset = 1'b0;
    #1;
    chk("arst_s_out", 32'(bus.s_out), 32'h00);
    chk("arst_r_out", 32'(bus.r_out), 32'h00);
    chk("arst_err", 32'(bus.err), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_ready", 32'(bus.tgt_ready), 32'd1);
    cyc();
    reset = 1'b1;

    // ---- q=0x00, tgt=0xA5 ----
    bus.tgt = 8'hA5; bus.tgt_valid = 1'b1;
    cyc();
    bus.tgt_valid = 1'b0;
    $display("txn tgt=0xA5 q=0x00 s_out=0x%0h r_out=0x%0h", bus.s_out, bus.r_out);
    chk("a5_s_out", 32'(bus.s_out), 32'hA5);
    chk("a5_r_out", 32'(bus.r_out), 32'h00);
    chk("a5_ready_busy", 32'(bus.tgt_ready), 32'd0);
    cyc();
    chk("a5_settle_done", 32'(bus.done), 32'd0);
    cyc();
    chk("a5_check_done", 32'(bus.done), 32'd0);
    cyc();
    chk("a5_done", 32'(bus.done), 32'd1);
    chk("a5_retry", 32'(bus.retry_cnt), 32'd0);
    chk("a5_err", 32'(bus.err), 32'd0);
    chk("a5_ready", 32'(bus.tgt_ready), 32'd1);

    // ---- q=0xFF, tgt=0x0F ----
    q_load_en = 1'b1; q_load_val = 8'hFF;
    cyc();
    chk("a5_done_pulse_end", 32'(bus.done), 32'd0);
    q_load_en = 1'b0;
    bus.tgt = 8'h0F; bus.tgt_valid = 1'b1;
    cyc();
    bus.tgt_valid = 1'b0;
    $display("txn tgt=0x0F q=0xFF s_out=0x%0h r_out=0x%0h", bus.s_out, bus.r_out);
    chk("0f_s_out", 32'(bus.s_out), 32'h00);
    chk("0f_r_out", 32'(bus.r_out), 32'hF0);
    cyc();
    cyc();
    chk("0f_check_done", 32'(bus.done), 32'd0);
    cyc();
    chk("0f_done", 32'(bus.done), 32'd1);
    chk("0f_q_bank", 32'(q_bank), 32'h0F);

    // ---- bit 0 stuck at 0, tgt=0x01: four drives then err ----
    q_load_en = 1'b1; q_load_val = 8'h00;
    cyc();
    q_load_en = 1'b0; stuck0 = 8'h01;
    bus.tgt = 8'h01; bus.tgt_valid = 1'b1;
    cyc();
    bus.tgt_valid = 1'b0;
    for (int a = 0; a < 4; a++) begin
      $display("txn stuck attempt=%0d s_out=0x%0h retry_cnt=%0d", a, bus.s_out, bus.retry_cnt);
      chk("stuck_drive_s_out", 32'(bus.s_out), 32'h01);
      chk("stuck_drive_r_out", 32'(bus.r_out), 32'h00);
      chk("stuck_retry_cnt", 32'(bus.retry_cnt), 32'(a));
      cyc();
      chk("stuck_settle_done", 32'(bus.done), 32'd0);
      cyc();
      chk("stuck_check_err", 32'(bus.err), 32'd0);
      cyc();
    end
    chk("stuck_err", 32'(bus.err), 32'd1);
    chk("stuck_retry_final", 32'(bus.retry_cnt), 32'd3);
    chk("stuck_done", 32'(bus.done), 32'd0);
    chk("stuck_ready", 32'(bus.tgt_ready), 32'd1);
    chk("stuck_state_idle", 32'(st), 32'd0);
    cyc();
    chk("stuck_err_hold", 32'(bus.err), 32'd1);
    chk("stuck_retry_hold", 32'(bus.retry_cnt), 32'd3);

    // ---- q=0x00 (bit 0 still stuck), tgt=0x3C: err clears on accept ----
    bus.tgt = 8'h3C; bus.tgt_valid = 1'b1;
    cyc();
    bus.tgt_valid = 1'b0;
    $display("txn tgt=0x3C q=0x00 s_out=0x%0h r_out=0x%0h", bus.s_out, bus.r_out);
    chk("3c_s_out", 32'(bus.s_out), 32'h3C);
    chk("3c_err_cleared", 32'(bus.err), 32'd0);
    chk("3c_retry_cleared", 32'(bus.retry_cnt), 32'd0);
    cyc();
    cyc();
    cyc();
    chk("3c_done", 32'(bus.done), 32'd1);

    // ---- back-to-back accept with tgt == q_fb == 0x3C ----
    bus.tgt = 8'h3C; bus.tgt_valid = 1'b1;
    cyc();
    bus.tgt_valid = 1'b0;
    $display("txn tgt=0x3C q=0x3C s_out=0x%0h r_out=0x%0h", bus.s_out, bus.r_out);
    chk("eq_ready_busy", 32'(bus.tgt_ready), 32'd0);
    chk("eq_state_drive", 32'(st), 32'd1);
    chk("eq_s_out", 32'(bus.s_out), 32'h00);
    chk("eq_r_out", 32'(bus.r_out), 32'h00);
    cyc();
    // A stray target during SETTLE must not be latched.
    bus.tgt = 8'hFF; bus.tgt_valid = 1'b1;
    cyc();
    bus.tgt_valid = 1'b0;
    chk("eq_ignore_state", 32'(st), 32'd3);
    chk("eq_ignore_s_out", 32'(bus.s_out), 32'h00);
    chk("eq_check_done", 32'(bus.done), 32'd0);
    cyc();
    chk("eq_done", 32'(bus.done), 32'd1);
    chk("eq_q_bank", 32'(q_bank), 32'h3C);
    cyc();
    chk("eq_done_pulse_end", 32'(bus.done), 32'd0);
    chk("eq_ready_after", 32'(bus.tgt_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/srff_driver.md
SRFF_DRIVER -- requirements
Module: srff_driver

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of SR flip-flop bits driven.
REQ-002 The block SHALL have parameter MAX_RETRY, default 3, giving the maximum re-drive attempts (legal range 1..15).

Interface
REQ-003 clk  input  1  clock; all state SHALL update on the falling edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 tgt  input  WIDTH  target state word for the external SR flip-flop bank.
REQ-006 tgt_valid  input  1  tgt is valid this cycle.
REQ-007 tgt_ready  output  1  block idle and able to accept tgt.
REQ-008 q_fb  input  WIDTH  feedback of the current q of the external flip-flop bank.
REQ-009 s_out  output  WIDTH  set excitation, one bit per flip-flop.
REQ-010 r_out  output  WIDTH  reset excitation, one bit per flip-flop.
REQ-011 done  output  1  one-cycle pulse: q_fb matched the target.
REQ-012 err  output  1  target not reached within MAX_RETRY re-drives.
REQ-013 retry_cnt  output  4  number of re-drives performed for the current target.

Function
REQ-014 The FSM SHALL have states IDLE, DRIVE, SETTLE and CHECK, encoded in 2 bits.
REQ-015 tgt_ready SHALL equal (state==IDLE) combinationally.
REQ-016 Accept: at a falling edge in IDLE with tgt_valid=1, tgt SHALL be latched into tgt_q, retry_cnt cleared, err cleared, and state set to DRIVE.
REQ-017 Excitation per bit SHALL be registered on entry to DRIVE:
- target 1 and q_fb 0 -> s=1, r=0
- target 0 and q_fb 1 -> s=0, r=1
- otherwise -> s=0, r=0
REQ-018 On accept, the excitation SHALL use the incoming tgt; on retry, it SHALL use tgt_q.
REQ-019 s_out and r_out SHALL be non-zero only during DRIVE (exactly one cycle per attempt) and SHALL be cleared on the edge leaving DRIVE.
REQ-020 s_out & r_out SHALL equal 0 in every cycle; the forbidden S=R=1 condition SHALL never be driven.
REQ-021 DRIVE SHALL go to SETTLE and SETTLE SHALL go to CHECK unconditionally, one edge each.
REQ-022 CHECK, q_fb==tgt_q: done SHALL be asserted for one cycle and state SHALL go to IDLE.
REQ-023 CHECK, mismatch and retry_cnt<MAX_RETRY: retry_cnt SHALL increment, excitation SHALL be re-registered, and state SHALL go to DRIVE.
REQ-024 CHECK, mismatch and retry_cnt==MAX_RETRY: err SHALL be set, state SHALL go to IDLE, and done SHALL stay 0.
REQ-025 Latency: done SHALL rise at the 4th falling edge after the accept edge (accept, DRIVE->SETTLE, SETTLE->CHECK, CHECK) when no retry occurs; each retry SHALL add 3 edges.
REQ-026 A target equal to q_fb SHALL still traverse DRIVE with s_out=r_out=0 and complete with the REQ-025 latency.
REQ-027 tgt_valid outside IDLE SHALL be ignored, with no latch and no state change.
REQ-028 err SHALL stay high until the next accept; retry_cnt SHALL hold its final value until the next accept.
REQ-029 An accept SHALL be possible in the cycle immediately after done or err, with no idle bubble required.

Reset
REQ-030 reset=0 SHALL immediately, independent of clk, force state=IDLE, s_out=0, r_out=0, done=0, err=0, retry_cnt=0 and tgt_q=0.
REQ-031 Reset asserted mid-operation (any state) SHALL abandon the target with no done or err; tgt_ready SHALL be 1 while reset is low.
REQ-032 The first accept SHALL be possible at the first falling edge after reset rises.

Verification (WIDTH=8, MAX_RETRY=3; bench models the SR bank updating q on the falling edge)
REQ-033 reset=0 pulsed while state=DRIVE with s_out=0xA5 -> s_out=0x00, r_out=0x00, err=0 within the same cycle, without waiting for a clock edge; tgt_ready=1.
REQ-034 q_fb=0x00, tgt=0xA5 accepted -> DRIVE s_out=0xA5, r_out=0x00; done pulse at the 4th edge; retry_cnt=0; err=0.
REQ-035 q_fb=0xFF, tgt=0x0F -> s_out=0x00, r_out=0xF0; done after 4 edges.
REQ-036 Model bit 0 stuck at 0, tgt=0x01 -> four DRIVE cycles each with s_out=0x01; then err=1, retry_cnt=3, done never asserted; tgt_ready=1 afterwards.
REQ-037 tgt=q_fb=0x3C -> s_out=r_out=0x00 throughout; done after 4 edges. A second tgt_valid pulse during SETTLE SHALL be ignored.
REQ-038 An assertion SHALL check (s_out & r_out)==0 and (s_out|r_out)==0 outside DRIVE on every cycle of all scenarios.
